// File: rtl/fu_issue_arbiter_pkg.sv
// Shared definitions for the functional-unit issue arbiter.
// Holds the FU type encoding, the instruction field layout, the queue
// depth and the busy-countdown width, plus a helper that extracts the
// FU type from an instruction byte.
package fu_issue_arbiter_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_T1  = 2'd1,
        FU_MUL = 2'd2,
        FU_DIV = 2'd3
    } fu_type_e;

    localparam int NUM_SLOTS = 4;
    localparam int NUM_FU    = 4;
    localparam int SLOT_W    = 2;
    localparam int CNT_W     = 3;
    localparam int INSTR_W   = 8;

    // Instruction byte layout: [7:6] FU type, [5:4] src0, [3:2] src1, [1:0] dest
    localparam int FU_TYPE_HI = 7;
    localparam int FU_TYPE_LO = 6;
    localparam int SRC0_HI    = 5;
    localparam int SRC0_LO    = 4;
    localparam int SRC1_HI    = 3;
    localparam int SRC1_LO    = 2;
    localparam int DEST_HI    = 1;
    localparam int DEST_LO    = 0;

    function automatic logic [1:0] fu_type_of(input logic [INSTR_W-1:0] instr);
        return instr[FU_TYPE_HI:FU_TYPE_LO];
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_countdown.sv
// Busy countdown for one functional unit.
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   load  - an instruction is being issued to this FU; start counting LAT
//   busy  - FU is executing (count non-zero)
//   done  - FU is in its final busy cycle; the owning slot retires next cycle
//           and the FU may accept a new instruction in this cycle
module fu_countdown
    import fu_issue_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] LAT = CNT_W'(1)
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic load,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] count;

    // Load on issue, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (load) begin
            count <= LAT;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);
    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/fu_issue_arbiter.sv
// Single-issue round-robin arbiter from a 4-entry ready queue onto four
// functional units with fixed latencies.
// Ports:
//   clk, reset (async, active-low), flush (sync abort of all in-flight work)
//   req_ready[3:0]       - slot k holds a valid, dependency-free instruction
//   req_instr_flat[31:0] - slot k instruction at [8k+7:8k]
//   issue_valid/slot/instr/fu_type - registered one-cycle issue pulse
//   retire_onehot[3:0]   - slot k completed this cycle
//   fu_busy[3:0]         - FU type f is executing
//   inflight[3:0]        - slot k issued and not yet retired
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int unsigned LAT_ALU = 1,
    parameter int unsigned LAT_T1  = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_SLOTS-1:0]         req_ready,
    input  logic [NUM_SLOTS*INSTR_W-1:0] req_instr_flat,
    output logic                         issue_valid,
    output logic [SLOT_W-1:0]            issue_slot,
    output logic [INSTR_W-1:0]           issue_instr,
    output logic [1:0]                   issue_fu_type,
    output logic [NUM_SLOTS-1:0]         retire_onehot,
    output logic [NUM_FU-1:0]            fu_busy,
    output logic [NUM_SLOTS-1:0]         inflight
);

    localparam logic [NUM_FU*CNT_W-1:0] LAT_PACK = {
        CNT_W'(LAT_DIV), CNT_W'(LAT_MUL), CNT_W'(LAT_T1), CNT_W'(LAT_ALU)
    };

    logic [INSTR_W-1:0] slot_instr [NUM_SLOTS];
    logic [1:0]         slot_fu    [NUM_SLOTS];
    logic [SLOT_W-1:0]  owner      [NUM_FU];
    logic [SLOT_W-1:0]  ptr;
    logic               armed;
    logic [NUM_FU-1:0]  fu_done;
    logic [NUM_FU-1:0]  fu_free;
    logic [NUM_FU-1:0]  fu_load;
    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] grant_onehot;
    logic [NUM_SLOTS-1:0] retire_next;
    logic               grant_valid;
    logic [SLOT_W-1:0]  grant_slot;
    logic [SLOT_W-1:0]  idx;

    // A FU in its last busy cycle counts as free so same-FU issue has no bubble.
    assign fu_free = ~fu_busy | fu_done;

    // Unpack the queue and decide which slots could issue this cycle.
    // 'armed' holds off the first grant until one clock after reset release.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_instr[k] = req_instr_flat[k*INSTR_W +: INSTR_W];
            slot_fu[k]    = fu_type_of(slot_instr[k]);
            eligible[k]   = armed & req_ready[k] & ~inflight[k] & fu_free[slot_fu[k]];
        end
    end

    // Round-robin search starting at the slot after the last one issued.
    always_comb begin
        grant_valid  = 1'b0;
        grant_slot   = '0;
        idx          = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = ptr + SLOT_W'(i);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_slot  = idx;
            end
        end
        if (grant_valid) begin
            grant_onehot[grant_slot] = 1'b1;
        end
    end

    // Map each finishing FU back to the slot it is executing for. The owner
    // used here is the pre-edge value, so a same-cycle re-load of the FU still
    // retires the previous occupant.
    always_comb begin
        retire_next = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (fu_done[f]) begin
                retire_next[owner[f]] = 1'b1;
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        assign fu_load[f] = grant_valid && (slot_fu[grant_slot] == 2'(f));

        fu_countdown #(
            .LAT (LAT_PACK[f*CNT_W +: CNT_W])
        ) u_countdown (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (fu_load[f]),
            .busy  (fu_busy[f]),
            .done  (fu_done[f])
        );
    end

    // Registered issue outputs, round-robin pointer, in-flight tracking and
    // retire pulses. Flush discards everything without retiring it; a slot
    // retiring this cycle leaves 'inflight' one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed         <= 1'b0;
            issue_valid   <= 1'b0;
            issue_slot    <= '0;
            issue_instr   <= '0;
            issue_fu_type <= '0;
            retire_onehot <= '0;
            inflight      <= '0;
            ptr           <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                owner[f] <= '0;
            end
        end else if (flush) begin
            issue_valid   <= 1'b0;
            issue_slot    <= '0;
            issue_instr   <= '0;
            issue_fu_type <= '0;
            retire_onehot <= '0;
            inflight      <= '0;
            ptr           <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                owner[f] <= '0;
            end
        end else begin
            armed         <= 1'b1;
            issue_valid   <= grant_valid;
            retire_onehot <= retire_next;
            inflight      <= (inflight & ~retire_onehot) | grant_onehot;
            if (grant_valid) begin
                issue_slot             <= grant_slot;
                issue_instr            <= slot_instr[grant_slot];
                issue_fu_type          <= slot_fu[grant_slot];
                ptr                    <= grant_slot + SLOT_W'(1);
                owner[slot_fu[grant_slot]] <= grant_slot;
            end else begin
                issue_slot    <= '0;
                issue_instr   <= '0;
                issue_fu_type <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed self-checking bench for fu_issue_arbiter (default latencies
// ALU=1, T1=2, MUL=3, DIV=5). "Cycle N" is the interval after the N-th rising
// edge following the cycle in which stimulus was applied; outputs are sampled
// 1 time unit after each rising edge and inputs change at the same point.
module tb_fu_issue_arbiter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [3:0]  req_ready;
    logic [31:0] req_instr_flat;
    logic        issue_valid;
    logic [1:0]  issue_slot;
    logic [7:0]  issue_instr;
    logic [1:0]  issue_fu_type;
    logic [3:0]  retire_onehot;
    logic [3:0]  fu_busy;
    logic [3:0]  inflight;

    int vectors;
    int miscompares;

    fu_issue_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req_ready      (req_ready),
        .req_instr_flat (req_instr_flat),
        .issue_valid    (issue_valid),
        .issue_slot     (issue_slot),
        .issue_instr    (issue_instr),
        .issue_fu_type  (issue_fu_type),
        .retire_onehot  (retire_onehot),
        .fu_busy        (fu_busy),
        .inflight       (inflight)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and let one edge pass so the next cycle is "cycle 0".
    task automatic do_reset();
        flush          = 1'b0;
        req_ready      = 4'b0000;
        req_instr_flat = 32'h0;
        reset          = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        flush          = 1'b0;
        req_ready      = 4'b1111;
        req_instr_flat = 32'h00000000;
        reset          = 1'b0;
        step();
        step();
        vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_issue_valid: got %0b expected 0", issue_valid); end
        vectors++; if (issue_slot !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_issue_slot: got %0d expected 0", issue_slot); end
        vectors++; if (issue_instr !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_issue_instr: got %0h expected 0", issue_instr); end
        vectors++; if (issue_fu_type !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_issue_fu_type: got %0d expected 0", issue_fu_type); end
        vectors++; if (retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_retire: got %b expected 0000", retire_onehot); end
        vectors++; if (fu_busy !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_fu_busy: got %b expected 0000", fu_busy); end
        vectors++; if (inflight !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_inflight: got %b expected 0000", inflight); end
        reset = 1'b1;
        step();
        vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_release_c1_valid: got %0b expected 0", issue_valid); end
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_release_c2_issue: got valid=%0b slot=%0d expected valid=1 slot=0", issue_valid, issue_slot); end
    endtask

    task automatic test_mixed_round_robin();
        logic [7:0] ins [4];
        logic [1:0] typ [4];
        logic [3:0] exp_ret [10];
        ins[0] = 8'h1B; ins[1] = 8'hB1; ins[2] = 8'h58; ins[3] = 8'hED;
        typ[0] = 2'd0;  typ[1] = 2'd2;  typ[2] = 2'd1;  typ[3] = 2'd3;
        exp_ret[1] = 4'b0000; exp_ret[2] = 4'b0001; exp_ret[3] = 4'b0000;
        exp_ret[4] = 4'b0000; exp_ret[5] = 4'b0110; exp_ret[9] = 4'b1000;
        do_reset();
        req_instr_flat = {ins[3], ins[2], ins[1], ins[0]};
        req_ready      = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c <= 4) begin
                vectors++;
                if (issue_valid !== 1'b1 || issue_slot !== 2'(c - 1) || issue_instr !== ins[c-1] || issue_fu_type !== typ[c-1]) begin
                    miscompares++;
                    $display("[TB] FAIL mixed_issue c%0d: got v=%0b s=%0d i=%0h t=%0d expected v=1 s=%0d i=%0h t=%0d",
                             c, issue_valid, issue_slot, issue_instr, issue_fu_type, c - 1, ins[c-1], typ[c-1]);
                end
            end
            if (c <= 5 || c == 9) begin
                vectors++;
                if (retire_onehot !== exp_ret[c]) begin miscompares++; $display("[TB] FAIL mixed_retire c%0d: got %b expected %b", c, retire_onehot, exp_ret[c]); end
            end
            if (c == 4) begin
                vectors++; if (fu_busy !== 4'b1110) begin miscompares++; $display("[TB] FAIL mixed_fu_busy c4: got %b expected 1110", fu_busy); end
                vectors++; if (inflight !== 4'b1110) begin miscompares++; $display("[TB] FAIL mixed_inflight c4: got %b expected 1110", inflight); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_instr_flat = {8'h00, 8'h00, 8'h1E, 8'h03};
        req_ready      = 4'b0011;
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd0) begin miscompares++; $display("[TB] FAIL b2b_c1_issue: got v=%0b s=%0d expected v=1 s=0", issue_valid, issue_slot); end
        vectors++; if (fu_busy !== 4'b0001) begin miscompares++; $display("[TB] FAIL b2b_c1_busy: got %b expected 0001", fu_busy); end
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd1 || issue_instr !== 8'h1E) begin miscompares++; $display("[TB] FAIL b2b_c2_issue: got v=%0b s=%0d i=%0h expected v=1 s=1 i=1e", issue_valid, issue_slot, issue_instr); end
        vectors++; if (retire_onehot !== 4'b0001) begin miscompares++; $display("[TB] FAIL b2b_c2_retire: got %b expected 0001", retire_onehot); end
        vectors++; if (fu_busy !== 4'b0001) begin miscompares++; $display("[TB] FAIL b2b_c2_busy: got %b expected 0001", fu_busy); end
        step();
        vectors++; if (retire_onehot !== 4'b0010) begin miscompares++; $display("[TB] FAIL b2b_c3_retire: got %b expected 0010", retire_onehot); end
        vectors++; if (issue_valid !== 1'b0 || issue_instr !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_c3_idle: got v=%0b i=%0h expected v=0 i=0", issue_valid, issue_instr); end
    endtask

    task automatic test_same_fu_div();
        do_reset();
        req_instr_flat = {8'h00, 8'hE4, 8'h00, 8'hC0};
        req_ready      = 4'b0101;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) begin
                vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd0) begin miscompares++; $display("[TB] FAIL div_c1_issue: got v=%0b s=%0d expected v=1 s=0", issue_valid, issue_slot); end
            end else if (c <= 5) begin
                vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL div_wait c%0d: got v=%0b expected 0", c, issue_valid); end
            end else if (c == 6) begin
                vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd2 || issue_fu_type !== 2'd3) begin miscompares++; $display("[TB] FAIL div_c6_issue: got v=%0b s=%0d t=%0d expected v=1 s=2 t=3", issue_valid, issue_slot, issue_fu_type); end
                vectors++; if (retire_onehot !== 4'b0001) begin miscompares++; $display("[TB] FAIL div_c6_retire: got %b expected 0001", retire_onehot); end
            end
            if (c <= 10) begin
                vectors++; if (fu_busy[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL div_busy c%0d: got %0b expected 1", c, fu_busy[3]); end
            end
            if (c == 11) begin
                vectors++; if (retire_onehot !== 4'b0100) begin miscompares++; $display("[TB] FAIL div_c11_retire: got %b expected 0100", retire_onehot); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_instr_flat = {8'h00, 8'h00, 8'h00, 8'h80};
        req_ready      = 4'b0001;
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_fu_type !== 2'd2) begin miscompares++; $display("[TB] FAIL flush_c1_issue: got v=%0b t=%0d expected v=1 t=2", issue_valid, issue_fu_type); end
        req_ready = 4'b0000;
        step();
        step();
        vectors++; if (fu_busy !== 4'b0100 || inflight !== 4'b0001) begin miscompares++; $display("[TB] FAIL flush_c3_state: got busy=%b infl=%b expected busy=0100 infl=0001", fu_busy, inflight); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (fu_busy !== 4'b0000 || inflight !== 4'b0000) begin miscompares++; $display("[TB] FAIL flush_c4_clear: got busy=%b infl=%b expected 0000/0000", fu_busy, inflight); end
        vectors++; if (issue_valid !== 1'b0 || retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL flush_c4_pulses: got v=%0b ret=%b expected 0/0000", issue_valid, retire_onehot); end
        for (int c = 5; c <= 8; c++) begin
            step();
            vectors++; if (retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL flush_no_retire c%0d: got %b expected 0000", c, retire_onehot); end
        end
        req_instr_flat = {8'h00, 8'h00, 8'h00, 8'h80};
        req_ready      = 4'b0011;
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd0) begin miscompares++; $display("[TB] FAIL flush_ptr_reset: got v=%0b s=%0d expected v=1 s=0", issue_valid, issue_slot); end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        req_instr_flat = {8'h00, 8'h00, 8'h00, 8'hC0};
        req_ready      = 4'b0001;
        step();
        step();
        step();
        #1;
        reset = 1'b0;
        #1;
        vectors++; if (issue_valid !== 1'b0 || issue_slot !== 2'd0 || issue_instr !== 8'h00 || issue_fu_type !== 2'd0) begin miscompares++; $display("[TB] FAIL midrst_issue: got v=%0b s=%0d i=%0h t=%0d expected all 0", issue_valid, issue_slot, issue_instr, issue_fu_type); end
        vectors++; if (fu_busy !== 4'b0000 || inflight !== 4'b0000 || retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL midrst_state: got busy=%b infl=%b ret=%b expected 0000", fu_busy, inflight, retire_onehot); end
        step();
        reset = 1'b1;
        step();
        vectors++; if (issue_valid !== 1'b0 || retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL midrst_c1: got v=%0b ret=%b expected 0/0000", issue_valid, retire_onehot); end
        step();
        vectors++; if (issue_valid !== 1'b1 || issue_slot !== 2'd0 || retire_onehot !== 4'b0000) begin miscompares++; $display("[TB] FAIL midrst_c2: got v=%0b s=%0d ret=%b expected 1/0/0000", issue_valid, issue_slot, retire_onehot); end
    endtask

    task automatic test_hold_once();
        int issues;
        issues = 0;
        do_reset();
        req_instr_flat = {8'h00, 8'h00, 8'h00, 8'hC3};
        req_ready      = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (issue_valid === 1'b1) issues++;
            vectors++; if (inflight[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_inflight c%0d: got %0b expected 1", c, inflight[0]); end
        end
        vectors++; if (retire_onehot !== 4'b0001) begin miscompares++; $display("[TB] FAIL hold_retire c6: got %b expected 0001", retire_onehot); end
        vectors++; if (issues !== 1) begin miscompares++; $display("[TB] FAIL hold_issue_count: got %0d expected 1", issues); end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b0;
        flush          = 1'b0;
        req_ready      = 4'b0000;
        req_instr_flat = 32'h0;
        test_reset();
        test_mixed_round_robin();
        test_back_to_back();
        test_same_fu_div();
        test_flush();
        test_reset_mid_div();
        test_hold_once();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
